result_accumulator: RTL and testbench

Downstream consumer of the 8x8 multiply pipeline's 16-bit result bus. It re-aligns a caller-supplied issue strobe to the pipeline's fixed latency and accumulates a frame of FRAME_LEN results. Per frame it produces the sum, the running maximum and the mean. The completed frame is handed to the next stage over a valid/ready handshake.

---
 rtl/result_acc_pkg.sv | 12 +
 rtl/result_accumulator_if.sv | 29 ++
 rtl/result_accumulator_vld_delay.sv | 19 +
 rtl/result_accumulator.sv | 92 +++++++++
 tb/tb_result_accumulator.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/result_acc_pkg.sv
// result_acc_pkg: shared state encoding and width helpers for result_accumulator.
package result_acc_pkg;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

    localparam int DROP_W = 8;

    function automatic int SUM_W(input int frame_len);
        return 16 + $clog2(frame_len);
    endfunction

endpackage

// File: rtl/result_accumulator_if.sv
// result_accumulator_if: sample/result bus of result_accumulator.
// drop_cnt exists only when RESULT_ACC_DROP_CNT_EN is defined.
interface result_accumulator_if #(parameter int FRAME_LEN = 16);
    import result_acc_pkg::*;

    logic                         start;
    logic                         in_valid;
    logic [15:0]                  data_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [SUM_W(FRAME_LEN)-1:0]  sum;
    logic [15:0]                  max;
    logic [15:0]                  mean;
    logic                         busy;
`ifdef RESULT_ACC_DROP_CNT_EN
    logic [DROP_W-1:0]            drop_cnt;

    modport master (output start, in_valid, data_in, out_ready,
                    input out_valid, sum, max, mean, busy, drop_cnt);
    modport slave  (input start, in_valid, data_in, out_ready,
                    output out_valid, sum, max, mean, busy, drop_cnt);
`else
    modport master (output start, in_valid, data_in, out_ready,
                    input out_valid, sum, max, mean, busy);
    modport slave  (input start, in_valid, data_in, out_ready,
                    output out_valid, sum, max, mean, busy);
`endif

endinterface

// File: rtl/result_accumulator_vld_delay.sv
// vld_delay: LATENCY-stage strobe delay so in_valid lines up with the multiply result.
module vld_delay #(
    parameter int LATENCY = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic aligned
);

    logic [LATENCY-1:0] sr_q, sr_d;

    always_comb sr_d = LATENCY'({sr_q, in_valid});

    always_ff @(posedge clk) sr_q <= rst ? '0 : sr_d;

    assign aligned = sr_q[LATENCY-1];

endmodule

// File: rtl/result_accumulator.sv
// result_accumulator: frames FRAME_LEN aligned multiply results into sum/max/mean.
// Define RESULT_ACC_DROP_CNT_EN to count samples discarded while a result waits.
module result_accumulator
    import result_acc_pkg::*;
#(
    parameter int LATENCY   = 3,
    parameter int FRAME_LEN = 16
) (
    input logic clk,
    input logic rst,
    result_accumulator_if.slave bus
);

    localparam int SW = SUM_W(FRAME_LEN);
    localparam int LG = $clog2(FRAME_LEN);

    state_e        state_q, state_d;
    logic [SW-1:0] acc_q, acc_d, sum_q, sum_d, acc_nxt;
    logic [15:0]   run_max_q, run_max_d, max_q, max_d, max_nxt;
    logic [LG-1:0] cnt_q, cnt_d;
    logic          aligned, take, last, clr;
`ifdef RESULT_ACC_DROP_CNT_EN
    logic [DROP_W-1:0] drop_q, drop_d;
`endif

    vld_delay #(.LATENCY(LATENCY)) u_vld (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid),
        .aligned  (aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            run_max_q <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            max_q     <= '0;
`ifdef RESULT_ACC_DROP_CNT_EN
            drop_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            run_max_q <= run_max_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
`ifdef RESULT_ACC_DROP_CNT_EN
            drop_q    <= drop_d;
`endif
        end
    end

    always_comb begin
        take    = state_q == ACC && aligned;
        last    = take && cnt_q == LG'(FRAME_LEN - 1);
        state_d = state_q == IDLE ? (bus.start ? ACC : IDLE)
                : state_q == ACC  ? (last ? DONE : ACC)
                : bus.out_ready   ? (bus.start ? ACC : IDLE) : DONE;
    end

    // Every entry to ACC starts a fresh frame, including the DONE->ACC shortcut.
    always_comb begin
        clr       = state_d == ACC && state_q != ACC;
        acc_nxt   = acc_q + SW'(bus.data_in);
        max_nxt   = bus.data_in > run_max_q ? bus.data_in : run_max_q;
        acc_d     = clr ? '0 : take ? acc_nxt : acc_q;
        run_max_d = clr ? '0 : take ? max_nxt : run_max_q;
        cnt_d     = clr ? '0 : take ? cnt_q + LG'(1) : cnt_q;
        sum_d     = last ? acc_nxt : sum_q;
        max_d     = last ? max_nxt : max_q;
`ifdef RESULT_ACC_DROP_CNT_EN
        drop_d    = clr ? '0
                  : (state_q == DONE && aligned && drop_q != '1) ? drop_q + DROP_W'(1) : drop_q;
`endif
    end

    always_comb begin
        bus.out_valid = state_q == DONE;
        bus.busy      = state_q == ACC;
        bus.sum       = sum_q;
        bus.max       = max_q;
        bus.mean      = 16'(sum_q >> LG);
`ifdef RESULT_ACC_DROP_CNT_EN
        bus.drop_cnt  = drop_q;
`endif
    end

endmodule

// File: tb/tb_result_accumulator.sv
// tb_result_accumulator: two instances (FRAME_LEN 4 and 16) share one stimulus stream;
// an issue-log reference model feeds a scoreboard checked by a negedge monitor.
module tb_result_accumulator;

    localparam int LAT = 3;
    localparam int FL [2] = '{4, 16};

    logic        clk, rst, start, in_valid, out_ready;
    logic [15:0] data_in;

    result_accumulator_if #(.FRAME_LEN(4))  if0 ();
    result_accumulator_if #(.FRAME_LEN(16)) if1 ();

    result_accumulator #(.LATENCY(LAT), .FRAME_LEN(4))  dut0 (.clk(clk), .rst(rst), .bus(if0));
    result_accumulator #(.LATENCY(LAT), .FRAME_LEN(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    assign if0.start = start;  assign if0.in_valid = in_valid;
    assign if0.data_in = data_in;  assign if0.out_ready = out_ready;
    assign if1.start = start;  assign if1.in_valid = in_valid;
    assign if1.data_in = data_in;  assign if1.out_ready = out_ready;

    logic [31:0] o_sum [2], o_max [2], o_mean [2];
    logic        o_ov [2], o_busy [2];
    assign o_sum[0] = 32'(if0.sum);   assign o_sum[1] = 32'(if1.sum);
    assign o_max[0] = 32'(if0.max);   assign o_max[1] = 32'(if1.max);
    assign o_mean[0] = 32'(if0.mean); assign o_mean[1] = 32'(if1.mean);
    assign o_ov[0] = if0.out_valid;   assign o_ov[1] = if1.out_valid;
    assign o_busy[0] = if0.busy;      assign o_busy[1] = if1.busy;
`ifdef RESULT_ACC_DROP_CNT_EN
    logic [31:0] o_drop [2];
    assign o_drop[0] = 32'(if0.drop_cnt); assign o_drop[1] = 32'(if1.drop_cnt);
`endif

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {int inst; longint s; int m; int mn;} res_t;
    res_t exp_q [$];

    int checks = 0, errors = 0;

    function automatic void chk(string nm, int i, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[inst%0d]: got %0d expected %0d at %0t", nm, i, act, exp, $time);
        end
    endfunction

    // Reference model: an issue log keyed by edge number decides which edges carry samples.
    int     ecnt = 0, last_rst = 0;
    bit     issued [int];
    logic [15:0] sched [int];
    int     mode [2], cnt [2], mdrop [2], mmax [2];
    longint msum [2];

    always @(posedge clk) begin
        bit al;
        ecnt++;
        al = !rst && ecnt - LAT > last_rst && issued.exists(ecnt - LAT);
        if (rst) last_rst = ecnt;
        else if (in_valid) issued[ecnt] = 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mode[i] = 0; mdrop[i] = 0;
                for (int j = exp_q.size() - 1; j >= 0; j--)
                    if (exp_q[j].inst == i) exp_q.delete(j);
            end else if (mode[i] == 0) begin
                if (start) begin mode[i] = 1; msum[i] = 0; mmax[i] = 0; cnt[i] = 0; mdrop[i] = 0; end
            end else if (mode[i] == 1) begin
                if (al) begin
                    msum[i] += data_in;
                    if (int'(data_in) > mmax[i]) mmax[i] = int'(data_in);
                    cnt[i]++;
                    if (cnt[i] == FL[i]) begin
                        exp_q.push_back('{i, msum[i], mmax[i], int'(msum[i] / FL[i])});
                        mode[i] = 2;
                    end
                end
            end else begin
                if (al && mdrop[i] < 255) mdrop[i]++;
                if (out_ready) begin
                    if (start) begin mode[i] = 1; msum[i] = 0; mmax[i] = 0; cnt[i] = 0; mdrop[i] = 0; end
                    else mode[i] = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        data_in = sched.exists(ecnt + 1) ? sched[ecnt + 1] : 16'($urandom);
    end

    always @(negedge clk) begin
        if (!rst) for (int i = 0; i < 2; i++) begin
            chk("busy", i, o_busy[i], mode[i] == 1);
            chk("out_valid", i, o_ov[i], mode[i] == 2);
`ifdef RESULT_ACC_DROP_CNT_EN
            chk("drop_cnt", i, o_drop[i], mdrop[i]);
`endif
            if (o_ov[i]) begin
                int j = -1;
                for (int k = 0; k < exp_q.size(); k++)
                    if (j < 0 && exp_q[k].inst == i) j = k;
                if (j < 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result[inst%0d]: out_valid=1 with no frame expected at %0t", i, $time);
                end else begin
                    chk("sum", i, o_sum[i], exp_q[j].s);
                    chk("max", i, o_max[i], exp_q[j].m);
                    chk("mean", i, o_mean[i], exp_q[j].mn);
                    if (out_ready) exp_q.delete(j);
                end
            end
        end
    end

    task automatic tick(input bit st, input bit v, input logic [15:0] val);
        start = st; in_valid = v;
        if (v) sched[ecnt + 1 + LAT] = val;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 0);
    endtask

    task automatic reset_check();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_out_valid", i, o_ov[i], 0);
            chk("rst_busy", i, o_busy[i], 0);
            chk("rst_sum", i, o_sum[i], 0);
            chk("rst_max", i, o_max[i], 0);
            chk("rst_mean", i, o_mean[i], 0);
`ifdef RESULT_ACC_DROP_CNT_EN
            chk("rst_drop", i, o_drop[i], 0);
`endif
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1; start = 0; in_valid = 0; out_ready = 0; data_in = 0;
        @(posedge clk); #1;
        idle(2);
        reset_check();
        rst = 0;
        // basic frame 10,20,30,40 then a held result while 3 samples are dropped
        tick(1, 0, 0);
        tick(0, 1, 10); tick(0, 1, 20); tick(0, 1, 30); tick(0, 1, 40);
        idle(3);
        for (int k = 0; k < 3; k++) tick(0, 1, 16'($urandom));
        idle(5);
        // back-to-back: start with out_ready, frame of ones
        out_ready = 1;
        tick(1, 1, 1); tick(0, 1, 1); tick(0, 1, 1); tick(0, 1, 1);
        idle(6);
        // gaps and ties
        tick(1, 0, 0);
        tick(0, 1, 7); tick(0, 0, 0); tick(0, 1, 7); tick(0, 1, 3); tick(0, 0, 0); tick(0, 1, 7);
        idle(6);
        // reset mid-frame with issues in flight, then a clean frame
        out_ready = 0;
        tick(1, 0, 0);
        tick(0, 1, 5); tick(0, 1, 5); tick(0, 1, 5);
        rst = 1;
        tick(0, 1, 9); tick(0, 1, 9);
        reset_check();
        rst = 0;
        tick(1, 1, 2); tick(0, 1, 4); tick(0, 1, 6); tick(0, 1, 8);
        idle(8);
        out_ready = 1;
        idle(2);
        // full scale on the 16-sample instance
        rst = 1; idle(2); rst = 0;
        tick(1, 1, 16'hFFFF);
        for (int k = 0; k < 15; k++) tick(0, 1, 16'hFFFF);
        idle(8);
        // random traffic
        for (int k = 0; k < 600; k++) begin
            out_ready = $urandom_range(0, 3) != 0;
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) == 0 ? 16'hFFFF : 16'($urandom));
        end
        out_ready = 1;
        idle(40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
